// File: rtl/pipeline_ctrl_sequencer.sv
`default_nettype none
// ============================================================================
// pipeline_ctrl_sequencer : stall/flush/freeze sequencer for the 5-stage core
// Optional perf counters: define PIPE_CTRL_PERF_EN
// Revision: 1.0
// ============================================================================
module pipeline_ctrl_sequencer #(
    parameter int unsigned FLUSH_CYCLES   = 1,
    parameter int unsigned MULDIV_TIMEOUT = 64
`ifdef PIPE_CTRL_PERF_EN
    ,
    parameter int unsigned CNT_W          = 32
`endif
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       hazard_stall,
    input  logic       branch_taken,
    input  logic       mem_busy,
    input  logic       muldiv_start,
    input  logic       muldiv_done,
    output logic       pc_en,
    output logic       if_id_en,
    output logic       id_ex_en,
    output logic       ex_mem_en,
    output logic       mem_wb_en,
    output logic       if_id_flush,
    output logic       id_ex_flush,
    output logic       ex_mem_bubble,
    output logic       redirect_apply,
    output logic [1:0] ctrl_state,
    output logic       timeout_err
`ifdef PIPE_CTRL_PERF_EN
    ,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_cycles,
    output logic [CNT_W-1:0] freeze_cycles
`endif
);

    localparam int unsigned FC_W  = (FLUSH_CYCLES > 1)   ? $clog2(FLUSH_CYCLES)   : 1;
    localparam int unsigned TMR_W = (MULDIV_TIMEOUT > 1) ? $clog2(MULDIV_TIMEOUT) : 1;

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_FLUSH   = 2'd1,
        ST_MULDIV  = 2'd2,
        ST_MEMWAIT = 2'd3
    } state_t;

    state_t            state_q, state_d;
    state_t            ret_state_q, ret_state_d;
    state_t            eval_state;
    logic [FC_W-1:0]   flush_cnt_q, flush_cnt_d;
    logic [TMR_W-1:0]  md_timer_q, md_timer_d;
    logic              redir_pend_q, redir_pend_d;
    logic              done_pend_q, done_pend_d;
    logic              timeout_err_q, timeout_err_d;
    logic              timeout_hit;
    logic              eval_branch;
    logic              eval_done;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= ST_RUN;
            ret_state_q   <= ST_RUN;
            flush_cnt_q   <= '0;
            md_timer_q    <= '0;
            redir_pend_q  <= 1'b0;
            done_pend_q   <= 1'b0;
            timeout_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            ret_state_q   <= ret_state_d;
            flush_cnt_q   <= flush_cnt_d;
            md_timer_q    <= md_timer_d;
            redir_pend_q  <= redir_pend_d;
            done_pend_q   <= done_pend_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        ret_state_d    = ret_state_q;
        flush_cnt_d    = flush_cnt_q;
        md_timer_d     = md_timer_q;
        redir_pend_d   = redir_pend_q;
        done_pend_d    = done_pend_q;
        timeout_err_d  = timeout_err_q;
        timeout_hit    = 1'b0;
        pc_en          = 1'b1;
        if_id_en       = 1'b1;
        id_ex_en       = 1'b1;
        ex_mem_en      = 1'b1;
        mem_wb_en      = 1'b1;
        if_id_flush    = 1'b0;
        id_ex_flush    = 1'b0;
        ex_mem_bubble  = 1'b0;
        redirect_apply = 1'b0;
        // Leaving MEMWAIT replays the frozen state with latched pulses folded in
        eval_state     = (state_q == ST_MEMWAIT) ? ret_state_q : state_q;
        eval_branch    = branch_taken | redir_pend_q;
        eval_done      = muldiv_done | done_pend_q;

        if (!rst_n) begin
            pc_en         = 1'b0;
            if_id_en      = 1'b0;
            id_ex_en      = 1'b0;
            ex_mem_en     = 1'b0;
            mem_wb_en     = 1'b0;
            if_id_flush   = 1'b1;
            id_ex_flush   = 1'b1;
            ex_mem_bubble = 1'b1;
        end else if (mem_busy) begin
            pc_en     = 1'b0;
            if_id_en  = 1'b0;
            id_ex_en  = 1'b0;
            ex_mem_en = 1'b0;
            mem_wb_en = 1'b0;
            state_d   = ST_MEMWAIT;
            if (state_q != ST_MEMWAIT) begin
                ret_state_d = state_q;
            end
            if (branch_taken) begin
                redir_pend_d = 1'b1;
            end
            if (muldiv_done) begin
                done_pend_d = 1'b1;
            end
        end else begin
            redir_pend_d = 1'b0;
            done_pend_d  = 1'b0;
            state_d      = eval_state;
            case (eval_state)
                ST_RUN, ST_FLUSH: begin
                    if (eval_branch) begin
                        redirect_apply = 1'b1;
                        if_id_flush    = 1'b1;
                        id_ex_flush    = 1'b1;
                        if (FLUSH_CYCLES > 1) begin
                            state_d     = ST_FLUSH;
                            flush_cnt_d = FC_W'(FLUSH_CYCLES - 1);
                        end else begin
                            state_d = ST_RUN;
                        end
                    end else if (eval_state == ST_FLUSH) begin
                        if_id_flush = 1'b1;
                        flush_cnt_d = flush_cnt_q - FC_W'(1);
                        if (flush_cnt_q <= FC_W'(1)) begin
                            state_d = ST_RUN;
                        end
                    end else if (muldiv_start) begin
                        pc_en         = 1'b0;
                        if_id_en      = 1'b0;
                        id_ex_en      = 1'b0;
                        ex_mem_bubble = 1'b1;
                        state_d       = ST_MULDIV;
                        md_timer_d    = '0;
                    end else if (hazard_stall) begin
                        pc_en         = 1'b0;
                        if_id_en      = 1'b0;
                        id_ex_en      = 1'b0;
                        ex_mem_bubble = 1'b1;
                    end
                end
                ST_MULDIV: begin
                    // branch_taken cannot legally occur here and is dropped
                    if (eval_done) begin
                        state_d = ST_RUN;
                    end else begin
                        pc_en         = 1'b0;
                        if_id_en      = 1'b0;
                        id_ex_en      = 1'b0;
                        ex_mem_bubble = 1'b1;
                        if ((MULDIV_TIMEOUT != 0) &&
                            (md_timer_q == TMR_W'(MULDIV_TIMEOUT - 1))) begin
                            timeout_hit   = 1'b1;
                            timeout_err_d = 1'b1;
                            state_d       = ST_RUN;
                        end else begin
                            md_timer_d = md_timer_q + TMR_W'(1);
                        end
                    end
                end
                default: begin
                    state_d = ST_RUN;
                end
            endcase
        end
    end

    assign ctrl_state  = state_q;
    assign timeout_err = timeout_err_q | timeout_hit;

`ifdef PIPE_CTRL_PERF_EN
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_perf_q, flush_cnt_perf_d;
    logic [CNT_W-1:0] freeze_cnt_q, freeze_cnt_d;
    logic             stall_evt, flush_evt, freeze_evt;

    // Outside reset and freeze, pc_en only drops for hazard or mul/div stalls
    always_comb begin
        stall_evt        = rst_n & ~mem_busy & ~pc_en;
        flush_evt        = rst_n & if_id_flush;
        freeze_evt       = rst_n & mem_busy;
        stall_cnt_d      = (stall_evt  && !(&stall_cnt_q))      ? stall_cnt_q + CNT_W'(1)      : stall_cnt_q;
        flush_cnt_perf_d = (flush_evt  && !(&flush_cnt_perf_q)) ? flush_cnt_perf_q + CNT_W'(1) : flush_cnt_perf_q;
        freeze_cnt_d     = (freeze_evt && !(&freeze_cnt_q))     ? freeze_cnt_q + CNT_W'(1)     : freeze_cnt_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stall_cnt_q      <= '0;
            flush_cnt_perf_q <= '0;
            freeze_cnt_q     <= '0;
        end else begin
            stall_cnt_q      <= stall_cnt_d;
            flush_cnt_perf_q <= flush_cnt_perf_d;
            freeze_cnt_q     <= freeze_cnt_d;
        end
    end

    assign stall_cycles  = stall_cnt_q;
    assign flush_cycles  = flush_cnt_perf_q;
    assign freeze_cycles = freeze_cnt_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pipeline_ctrl_sequencer.sv
`default_nettype none
// ============================================================================
// tb_pipeline_ctrl_sequencer : directed vector bench for the pipeline sequencer
// Revision: 1.0
// ============================================================================
module tb_pipeline_ctrl_sequencer;

    localparam int unsigned FLUSH_CYCLES   = 3;
    localparam int unsigned MULDIV_TIMEOUT = 8;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       hazard_stall, branch_taken, mem_busy, muldiv_start, muldiv_done;
    logic       pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en;
    logic       if_id_flush, id_ex_flush, ex_mem_bubble, redirect_apply;
    logic [1:0] ctrl_state;
    logic       timeout_err;
`ifdef PIPE_CTRL_PERF_EN
    logic [31:0] stall_cycles, flush_cycles, freeze_cycles;
`endif

    int checks = 0;
    int errors = 0;

    pipeline_ctrl_sequencer #(
        .FLUSH_CYCLES   (FLUSH_CYCLES),
        .MULDIV_TIMEOUT (MULDIV_TIMEOUT)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .hazard_stall   (hazard_stall),
        .branch_taken   (branch_taken),
        .mem_busy       (mem_busy),
        .muldiv_start   (muldiv_start),
        .muldiv_done    (muldiv_done),
        .pc_en          (pc_en),
        .if_id_en       (if_id_en),
        .id_ex_en       (id_ex_en),
        .ex_mem_en      (ex_mem_en),
        .mem_wb_en      (mem_wb_en),
        .if_id_flush    (if_id_flush),
        .id_ex_flush    (id_ex_flush),
        .ex_mem_bubble  (ex_mem_bubble),
        .redirect_apply (redirect_apply),
        .ctrl_state     (ctrl_state),
        .timeout_err    (timeout_err)
`ifdef PIPE_CTRL_PERF_EN
        ,
        .stall_cycles   (stall_cycles),
        .flush_cycles   (flush_cycles),
        .freeze_cycles  (freeze_cycles)
`endif
    );

    always #5 clk = ~clk;

    // Input word: {rst_n, mem_busy, branch_taken, muldiv_start, muldiv_done, hazard_stall}
    // Expected word: {pc,if_id,id_ex,ex_mem,mem_wb en}, {if_id_fl,id_ex_fl,bubble,redirect}, state, terr
    typedef struct {
        logic [5:0]  in;
        logic [4:0]  en;
        logic [3:0]  fl;
        logic [1:0]  st;
        logic        te;
        string       name;
    } vec_t;

    localparam logic [4:0] EN_ALL   = 5'b11111;
    localparam logic [4:0] EN_NONE  = 5'b00000;
    localparam logic [4:0] EN_STALL = 5'b00011;
    localparam logic [3:0] FL_NONE  = 4'b0000;
    localparam logic [3:0] FL_RST   = 4'b1110;
    localparam logic [3:0] FL_REDIR = 4'b1101;
    localparam logic [3:0] FL_IF    = 4'b1000;
    localparam logic [3:0] FL_BUB   = 4'b0010;

    localparam logic [5:0] I_RST    = 6'b000000;
    localparam logic [5:0] I_IDLE   = 6'b100000;
    localparam logic [5:0] I_BR     = 6'b101000;
    localparam logic [5:0] I_HZ     = 6'b100001;
    localparam logic [5:0] I_HZ_BR  = 6'b101001;
    localparam logic [5:0] I_MB     = 6'b110000;
    localparam logic [5:0] I_MB_BR  = 6'b111000;
    localparam logic [5:0] I_MB_DN  = 6'b110010;
    localparam logic [5:0] I_ST     = 6'b100100;
    localparam logic [5:0] I_ST_HZ  = 6'b100101;
    localparam logic [5:0] I_DN     = 6'b100010;
    localparam logic [5:0] I_ST_DN  = 6'b100110;

    vec_t vecs[$];

    task automatic add(input logic [5:0] in, input logic [4:0] en, input logic [3:0] fl,
                       input logic [1:0] st, input logic te, input string name);
        vec_t v;
        v.in = in; v.en = en; v.fl = fl; v.st = st; v.te = te; v.name = name;
        vecs.push_back(v);
    endtask

    task automatic drive(input logic [5:0] in);
        {rst_n, mem_busy, branch_taken, muldiv_start, muldiv_done, hazard_stall} = in;
    endtask

    task automatic check(input string name, input logic [4:0] en, input logic [3:0] fl,
                         input logic [1:0] st, input logic te);
        logic [11:0] act, exp;
        act = {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
               if_id_flush, id_ex_flush, ex_mem_bubble, redirect_apply, ctrl_state, timeout_err};
        exp = {en, fl, st, te};
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got en=%b fl=%b st=%0d te=%b, expected en=%b fl=%b st=%0d te=%b",
                     name, act[11:7], act[6:3], act[2:1], act[0], en, fl, st, te);
        end
    endtask

    // One cycle: drive after the edge, sample at the falling edge, advance
    task automatic step(input logic [5:0] in, input logic [4:0] en, input logic [3:0] fl,
                        input logic [1:0] st, input logic te, input string name);
        drive(in);
        @(negedge clk);
        check(name, en, fl, st, te);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        add(I_RST,   EN_NONE,  FL_RST,   2'd0, 1'b0, "reset_c0");
        add(I_RST,   EN_NONE,  FL_RST,   2'd0, 1'b0, "reset_c1");
        add(I_RST,   EN_NONE,  FL_RST,   2'd0, 1'b0, "reset_c2");
        add(I_IDLE,  EN_ALL,   FL_NONE,  2'd0, 1'b0, "idle_0");
        add(I_IDLE,  EN_ALL,   FL_NONE,  2'd0, 1'b0, "idle_1");
        add(I_BR,    EN_ALL,   FL_REDIR, 2'd0, 1'b0, "branch_c0");
        add(I_IDLE,  EN_ALL,   FL_IF,    2'd1, 1'b0, "branch_c1");
        add(I_IDLE,  EN_ALL,   FL_IF,    2'd1, 1'b0, "branch_c2");
        add(I_IDLE,  EN_ALL,   FL_NONE,  2'd0, 1'b0, "branch_c3_run");
        add(I_HZ_BR, EN_ALL,   FL_REDIR, 2'd0, 1'b0, "hz_br_redirect_wins");
        add(I_HZ,    EN_ALL,   FL_IF,    2'd1, 1'b0, "hz_ignored_flush_1");
        add(I_HZ,    EN_ALL,   FL_IF,    2'd1, 1'b0, "hz_ignored_flush_2");
        add(I_HZ,    EN_STALL, FL_BUB,   2'd0, 1'b0, "hz_stall_run");
        add(I_IDLE,  EN_ALL,   FL_NONE,  2'd0, 1'b0, "hz_release");
        add(I_BR,    EN_ALL,   FL_REDIR, 2'd0, 1'b0, "reload_br0");
        add(I_IDLE,  EN_ALL,   FL_IF,    2'd1, 1'b0, "reload_f1");
        add(I_BR,    EN_ALL,   FL_REDIR, 2'd1, 1'b0, "reload_br_in_flush");
        add(I_IDLE,  EN_ALL,   FL_IF,    2'd1, 1'b0, "reload_f2");
        add(I_IDLE,  EN_ALL,   FL_IF,    2'd1, 1'b0, "reload_f3");
        add(I_IDLE,  EN_ALL,   FL_NONE,  2'd0, 1'b0, "reload_run");
        add(I_MB,    EN_NONE,  FL_NONE,  2'd0, 1'b0, "membusy_c0");
        add(I_MB,    EN_NONE,  FL_NONE,  2'd3, 1'b0, "membusy_c1");
        add(I_MB_BR, EN_NONE,  FL_NONE,  2'd3, 1'b0, "membusy_c2_branch");
        add(I_MB,    EN_NONE,  FL_NONE,  2'd3, 1'b0, "membusy_c3");
        add(I_IDLE,  EN_ALL,   FL_REDIR, 2'd3, 1'b0, "membusy_drop_redirect");
        add(I_IDLE,  EN_ALL,   FL_IF,    2'd1, 1'b0, "membusy_flush_1");
        add(I_IDLE,  EN_ALL,   FL_IF,    2'd1, 1'b0, "membusy_flush_2");
        add(I_IDLE,  EN_ALL,   FL_NONE,  2'd0, 1'b0, "membusy_run");
        add(I_ST_HZ, EN_STALL, FL_BUB,   2'd0, 1'b0, "start_beats_hazard");
        add(I_DN,    EN_ALL,   FL_NONE,  2'd2, 1'b0, "start_hz_done");
        add(I_IDLE,  EN_ALL,   FL_NONE,  2'd0, 1'b0, "start_hz_run");
        add(I_ST,    EN_STALL, FL_BUB,   2'd0, 1'b0, "sd_start");
        add(I_ST_DN, EN_ALL,   FL_NONE,  2'd2, 1'b0, "sd_start_and_done");
        add(I_ST,    EN_STALL, FL_BUB,   2'd0, 1'b0, "sd_restart");
        add(I_BR,    EN_STALL, FL_BUB,   2'd2, 1'b0, "branch_in_muldiv_ignored");
        add(I_DN,    EN_ALL,   FL_NONE,  2'd2, 1'b0, "sd_done");
        add(I_IDLE,  EN_ALL,   FL_NONE,  2'd0, 1'b0, "sd_run");
        add(I_ST,    EN_STALL, FL_BUB,   2'd0, 1'b0, "dp_start");
        add(I_MB_DN, EN_NONE,  FL_NONE,  2'd2, 1'b0, "dp_busy_done");
        add(I_MB,    EN_NONE,  FL_NONE,  2'd3, 1'b0, "dp_busy");
        add(I_IDLE,  EN_ALL,   FL_NONE,  2'd3, 1'b0, "dp_pending_done");
        add(I_IDLE,  EN_ALL,   FL_NONE,  2'd0, 1'b0, "dp_run");

        drive(I_RST);
        @(posedge clk);
        #1;

        foreach (vecs[i]) begin
            step(vecs[i].in, vecs[i].en, vecs[i].fl, vecs[i].st, vecs[i].te, vecs[i].name);
        end

        // mul/div completing five cycles after start
        step(I_ST, EN_STALL, FL_BUB, 2'd0, 1'b0, "md5_start");
        for (int k = 1; k <= 4; k++) begin
            step(I_IDLE, EN_STALL, FL_BUB, 2'd2, 1'b0, $sformatf("md5_wait_%0d", k));
        end
        step(I_DN,   EN_ALL, FL_NONE, 2'd2, 1'b0, "md5_done");
        step(I_IDLE, EN_ALL, FL_NONE, 2'd0, 1'b0, "md5_run");

        // mul/div never completing: timeout on cycle 8, sticky until reset
        step(I_ST, EN_STALL, FL_BUB, 2'd0, 1'b0, "to_start");
        for (int k = 1; k <= 7; k++) begin
            step(I_IDLE, EN_STALL, FL_BUB, 2'd2, 1'b0, $sformatf("to_wait_%0d", k));
        end
        step(I_IDLE, EN_STALL, FL_BUB, 2'd2, 1'b1, "to_timeout");
        for (int k = 0; k < 3; k++) begin
            step(I_IDLE, EN_ALL, FL_NONE, 2'd0, 1'b1, $sformatf("to_sticky_%0d", k));
        end
        step(I_RST,  EN_NONE, FL_RST,  2'd0, 1'b1, "to_reset_cycle");
        step(I_IDLE, EN_ALL,  FL_NONE, 2'd0, 1'b0, "to_cleared");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
